cursor_move_ctrl: RTL and testbench

Consumer of the debounced button command stream (3-bit direction/ENTER code plus one-cycle enable). Moves a board cursor, collects the three coordinates of an Amazons move (queen, destination, arrow), and hands the completed move to the board engine over a valid/ready handshake. Sits between button decode and board-state logic; also drives cursor and phase information to the VGA renderer.

---
 rtl/amazons_pkg.sv | 26 ++
 rtl/cursor_axis.sv | 32 +++
 rtl/cursor_move_ctrl.sv | 132 +++++++++++++
 tb/tb_cursor_move_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/amazons_pkg.sv
// Purpose : shared command codes, phase encoding and board size for the Amazons game datapath.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package amazons_pkg;

   localparam int BOARD_N_DEF = 10;

   // Button command codes; 6 and 7 are unused and behave as CMD_NULL.
   typedef enum logic [2:0] {
      CMD_NULL  = 3'd0,
      CMD_UP    = 3'd1,
      CMD_DOWN  = 3'd2,
      CMD_LEFT  = 3'd3,
      CMD_RIGHT = 3'd4,
      CMD_ENTER = 3'd5
   } cmd_e;

   // Move-entry phases, also shown to the renderer.
   typedef enum logic [1:0] {
      SEL_QUEEN = 2'd0,
      SEL_DEST  = 2'd1,
      SEL_ARROW = 2'd2,
      COMMIT    = 2'd3
   } phase_e;

endpackage

// File: rtl/cursor_axis.sv
// Purpose : saturating up/down position counter over 0..N-1 for one cursor axis.
// Latency : one cycle from inc/dec to pos.
// Backpressure: none; hold=1 freezes the count.
// Ports   : clk, rst_n (sync, active low), inc, dec, hold -> pos[CW-1:0].
module cursor_axis #(
   parameter int N  = 10,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   input  logic          hold,
   output logic [CW-1:0] pos
);

   localparam logic [CW-1:0] POS_MAX = CW'(N - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos <= '0;
      end else if (!hold) begin
         // inc and dec together cancel out rather than picking a winner.
         if (inc && !dec && pos != POS_MAX) begin
            pos <= pos + 1'b1;
         end else if (dec && !inc && pos != '0) begin
            pos <= pos - 1'b1;
         end
      end
   end

endmodule

// File: rtl/cursor_move_ctrl.sv
// Purpose : moves the board cursor, collects queen/destination/arrow and offers the move to the board engine.
// Latency : one cycle from a strobed command to cursor/phase/latch outputs; move_valid is registered.
// Backpressure: move and move_valid held in COMMIT until move_ready=1; commands in COMMIT are dropped.
// Ports   : clk, rst_n, cmd[2:0]/cmd_en in; cur_x/cur_y, phase, q/d/a coords, player, move_valid out; move_ready in.
module cursor_move_ctrl
   import amazons_pkg::*;
#(
   parameter int BOARD_N = BOARD_N_DEF,
   parameter int CW      = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    cmd,
   input  logic          cmd_en,
   output logic [CW-1:0] cur_x,
   output logic [CW-1:0] cur_y,
   output logic [1:0]    phase,
   output logic [CW-1:0] q_x,
   output logic [CW-1:0] q_y,
   output logic [CW-1:0] d_x,
   output logic [CW-1:0] d_y,
   output logic [CW-1:0] a_x,
   output logic [CW-1:0] a_y,
   output logic          player,
   output logic          move_valid,
   input  logic          move_ready
);

   phase_e phase_q, phase_nxt;
   logic   lat_q, lat_d, lat_a, toggle;
   logic   axis_hold, is_enter;

   // The cursor freezes while a move is on offer, and on any non-strobed cycle.
   assign axis_hold = !cmd_en || (phase_q == COMMIT);
   assign is_enter  = cmd_en && (cmd == CMD_ENTER);
   assign phase     = phase_q;

   cursor_axis #(.N(BOARD_N), .CW(CW)) u_axis_x (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (cmd == CMD_RIGHT),
      .dec  (cmd == CMD_LEFT),
      .hold (axis_hold),
      .pos  (cur_x)
   );

   cursor_axis #(.N(BOARD_N), .CW(CW)) u_axis_y (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (cmd == CMD_DOWN),
      .dec  (cmd == CMD_UP),
      .hold (axis_hold),
      .pos  (cur_y)
   );

   always_comb begin
      phase_nxt = phase_q;
      lat_q     = 1'b0;
      lat_d     = 1'b0;
      lat_a     = 1'b0;
      toggle    = 1'b0;
      case (phase_q)
         SEL_QUEEN: begin
            if (is_enter) begin
               lat_q     = 1'b1;
               phase_nxt = SEL_DEST;
            end
         end
         SEL_DEST: begin
            // ENTER on the queen square again backs out; q keeps its old value.
            if (is_enter) begin
               if (cur_x == q_x && cur_y == q_y) begin
                  phase_nxt = SEL_QUEEN;
               end else begin
                  lat_d     = 1'b1;
                  phase_nxt = SEL_ARROW;
               end
            end
         end
         SEL_ARROW: begin
            if (is_enter) begin
               if (cur_x == d_x && cur_y == d_y) begin
                  phase_nxt = SEL_DEST;
               end else begin
                  lat_a     = 1'b1;
                  phase_nxt = COMMIT;
               end
            end
         end
         default: begin
            // Handshake wins over any coincident command, which is simply lost.
            if (move_ready) begin
               phase_nxt = SEL_QUEEN;
               toggle    = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q    <= SEL_QUEEN;
         q_x        <= '0;
         q_y        <= '0;
         d_x        <= '0;
         d_y        <= '0;
         a_x        <= '0;
         a_y        <= '0;
         player     <= 1'b0;
         move_valid <= 1'b0;
      end else begin
         phase_q <= phase_nxt;
         if (lat_q) begin
            q_x <= cur_x;
            q_y <= cur_y;
         end
         if (lat_d) begin
            d_x <= cur_x;
            d_y <= cur_y;
         end
         if (lat_a) begin
            a_x <= cur_x;
            a_y <= cur_y;
         end
         if (toggle) begin
            player <= ~player;
         end
         move_valid <= (phase_nxt == COMMIT);
      end
   end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
module tb_cursor_move_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] cmd;
   logic       cmd_en;
   logic [3:0] cur_x, cur_y, q_x, q_y, d_x, d_y, a_x, a_y;
   logic [1:0] phase;
   logic       player, move_valid, move_ready;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: plain integers following the game rules.
   int mx, my, mph, mqx, mqy, mdx, mdy, max_, may, mpl;

   always #5 clk = ~clk;

   cursor_move_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .cmd_en    (cmd_en),
      .cur_x     (cur_x),
      .cur_y     (cur_y),
      .phase     (phase),
      .q_x       (q_x),
      .q_y       (q_y),
      .d_x       (d_x),
      .d_y       (d_y),
      .a_x       (a_x),
      .a_y       (a_y),
      .player    (player),
      .move_valid(move_valid),
      .move_ready(move_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit en, input int c, input bit rdy, input bit rn);
      if (!rn) begin
         mx = 0; my = 0; mph = 0; mqx = 0; mqy = 0;
         mdx = 0; mdy = 0; max_ = 0; may = 0; mpl = 0;
      end else if (mph == 3) begin
         if (rdy) begin
            mph = 0;
            mpl = 1 - mpl;
         end
      end else if (en) begin
         case (c)
            1: my = (my > 0) ? my - 1 : my;
            2: my = (my < 9) ? my + 1 : my;
            3: mx = (mx > 0) ? mx - 1 : mx;
            4: mx = (mx < 9) ? mx + 1 : mx;
            5: begin
               if (mph == 0) begin
                  mqx = mx; mqy = my; mph = 1;
               end else if (mph == 1) begin
                  if (mx == mqx && my == mqy) mph = 0;
                  else begin mdx = mx; mdy = my; mph = 2; end
               end else begin
                  if (mx == mdx && my == mdy) mph = 1;
                  else begin max_ = mx; may = my; mph = 3; end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      chk("cur_x", cur_x, mx);
      chk("cur_y", cur_y, my);
      chk("phase", phase, mph);
      chk("q_x", q_x, mqx);
      chk("q_y", q_y, mqy);
      chk("d_x", d_x, mdx);
      chk("d_y", d_y, mdy);
      chk("a_x", a_x, max_);
      chk("a_y", a_y, may);
      chk("player", player, mpl);
      chk("move_valid", move_valid, (mph == 3) ? 1 : 0);
   endtask

   // Drive one cycle of inputs, let the edge pass, then compare 1 time unit later.
   task automatic step(input bit en, input int c, input bit rdy, input bit rn);
      rst_n      = rn;
      cmd_en     = en;
      cmd        = 3'(c);
      move_ready = rdy;
      @(posedge clk);
      model(en, c, rdy, rn);
      #1;
      check_all();
      cmd_en     = 1'b0;
      move_ready = 1'b0;
      rst_n      = 1'b1;
   endtask

   task automatic press(input int c, input int times);
      for (int i = 0; i < times; i++) step(1'b1, c, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; cmd = 3'd0; cmd_en = 1'b0; move_ready = 1'b0;
      #2;
      // Reset state
      step(1'b0, 0, 1'b0, 1'b0);

      // Basic moves, one-cycle latency each
      press(4, 3);
      press(2, 2);
      chk("dir_cx", cur_x, 3);
      chk("dir_cy", cur_y, 2);
      step(1'b0, 5, 1'b0, 1'b1);   // ENTER without strobe is ignored
      press(0, 1); press(6, 1); press(7, 1);

      // Saturation at the low and high edges
      step(1'b0, 0, 1'b0, 1'b0);
      press(1, 1);
      press(3, 1);
      press(4, 12);
      chk("sat_cx", cur_x, 9);

      // Full move: queen (3,0), dest (3,5), arrow (6,5)
      press(3, 6);
      press(5, 1);
      press(2, 5);
      press(5, 1);
      press(4, 3);
      step(1'b0, 0, 1'b1, 1'b1);   // move_ready outside COMMIT has no effect
      press(5, 1);
      chk("commit_ph", phase, 3);
      chk("commit_qy", q_y, 0);
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);
      chk("hs_player", player, 1);

      // Cancel paths
      press(3, 3);
      press(1, 5);
      press(5, 2);                 // queen cancel
      press(5, 1);
      press(2, 5);
      press(5, 1);
      press(5, 1);                 // dest cancel
      chk("cancel_ph", phase, 1);
      press(4, 1);
      press(5, 1);
      press(5, 1);
      press(4, 1);
      press(5, 1);

      // Commands in COMMIT are dropped, also when coincident with move_ready
      press(2, 1);
      press(5, 1);
      step(1'b1, 2, 1'b1, 1'b1);

      // Reset while a move is on offer, with a command strobed
      press(5, 1); press(4, 1); press(5, 1); press(4, 1); press(5, 1);
      chk("pre_rst_mv", move_valid, 1);
      step(1'b1, 4, 1'b1, 1'b0);

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
